// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and sizing helpers
// for the SPI burst register-file slave.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WR,
    RD,
    DRAIN
  } state_e;

  localparam logic RW_READ = 1'b1;

  function automatic int hdr_len(input int aw);
    return 1 + aw;
  endfunction

  function automatic int cnt_width(input int dw, input int aw);
    int m;
    m = (dw > 1 + aw) ? dw : 1 + aw;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_burst_regfile_slave_if.sv
// spi_burst_regfile_slave_if: SPI pin bundle plus
// the per-frame mode selects.
interface spi_burst_regfile_slave_if;
  logic sck;
  logic ss_n;
  logic mosi;
  logic cpol;
  logic cpha;
  logic miso;
  logic miso_oe;

  modport master (
    output sck, ss_n, mosi, cpol, cpha,
    input  miso, miso_oe
  );

  modport slave (
    input  sck, ss_n, mosi, cpol, cpha,
    output miso, miso_oe
  );
endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronizes sck/ss_n/mosi and turns
// sck transitions into mode-aware sample/shift pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  input  logic cpol,
  input  logic cpha,
  output logic sample_pulse,
  output logic shift_pulse,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic sck_d;
  logic ss_d;
  logic sck_s;
  logic ss_s;
  logic lead;
  logic trail;

  // ss_n resets low so a select already held low
  // at reset release never looks like a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q  <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      ss_d   <= 1'b0;
    end else begin
      sck_q  <= (sck_q << 1) | SYNC_STAGES'(sck);
      ss_q   <= (ss_q << 1) | SYNC_STAGES'(ss_n);
      mosi_q <= (mosi_q << 1) | SYNC_STAGES'(mosi);
      sck_d  <= sck_q[SYNC_STAGES-1];
      ss_d   <= ss_q[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign ss_s   = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign lead  = (sck_d == cpol) && (sck_s != cpol);
  assign trail = (sck_d != cpol) && (sck_s == cpol);

  assign sample_pulse = cpha ? trail : lead;
  assign shift_pulse  = cpha ? lead : trail;
  assign ss_fall = ss_d & ~ss_s;
  assign ss_rise = ~ss_d & ss_s;

endmodule

// File: rtl/spi_burst_regfile_slave.sv
// spi_burst_regfile_slave: SPI register-file slave with
// burst read/write, auto-increment and host read port.
module spi_burst_regfile_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  spi_burst_regfile_slave_if.slave spi,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic frame_done,
  output logic frame_abort,
  output logic addr_err
);

  localparam int HL = hdr_len(ADDR_WIDTH);
  localparam int CW = cnt_width(DATA_WIDTH, ADDR_WIDTH);
  localparam logic [CW-1:0] HDR_LAST = CW'(HL - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e state, state_n;
  logic cpol_q, cpha_q;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-2:0] shift_in;
  logic [DATA_WIDTH-1:0] shift_out;
  logic [ADDR_WIDTH-1:0] addr;
  logic miso_q;
  logic [DATA_WIDTH-1:0] regfile [DEPTH];

  logic sample_pulse, shift_pulse;
  logic ss_fall, ss_rise, mosi_s;

  logic [DATA_WIDTH-1:0] word_bits;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [CW-1:0] rd_bound;
  logic hdr_rw, hdr_oob, host_ok;
  logic hdr_shift, hdr_done;
  logic wr_shift, word_done;
  logic rd_shift, rd_last;
  logic done_n, abort_n, err_n;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .reset_n      (reset_n),
    .sck          (spi.sck),
    .ss_n         (spi.ss_n),
    .mosi         (spi.mosi),
    .cpol         (cpol_q),
    .cpha         (cpha_q),
    .sample_pulse (sample_pulse),
    .shift_pulse  (shift_pulse),
    .ss_fall      (ss_fall),
    .ss_rise      (ss_rise),
    .mosi_s       (mosi_s)
  );

  assign word_bits = {shift_in, mosi_s};
  assign hdr_rw    = word_bits[HL-1];
  assign hdr_addr  = word_bits[ADDR_WIDTH-1:0];
  assign hdr_oob   = {1'b0, hdr_addr} >= DEPTH_W;
  assign host_ok   = {1'b0, host_addr} < DEPTH_W;
  assign next_addr = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
  // cpha=0 masters add one trailing (shift) edge after the final sampled bit.
  assign rd_bound  = cpha_q ? '0 : CW'(1);

  assign spi.miso_oe = (state == RD);
  assign spi.miso    = (state == RD) & miso_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    hdr_shift = 1'b0;
    hdr_done  = 1'b0;
    wr_shift  = 1'b0;
    word_done = 1'b0;
    rd_shift  = 1'b0;
    rd_last   = 1'b0;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: if (ss_fall) state_n = HEADER;
      HEADER: begin
        if (ss_rise) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (sample_pulse) begin
          hdr_shift = 1'b1;
          if (bit_cnt == HDR_LAST) begin
            hdr_done = 1'b1;
            if (hdr_oob) begin
              err_n   = 1'b1;
              state_n = DRAIN;
            end else if (hdr_rw == RW_READ) begin
              state_n = RD;
            end else begin
              state_n = WR;
            end
          end
        end
      end
      WR: begin
        if (ss_rise) begin
          state_n = IDLE;
          done_n  = (bit_cnt == '0);
          abort_n = (bit_cnt != '0);
        end else if (sample_pulse) begin
          wr_shift  = 1'b1;
          word_done = (bit_cnt == WORD_LAST);
        end
      end
      RD: begin
        if (ss_rise) begin
          state_n = IDLE;
          done_n  = (bit_cnt == rd_bound);
          abort_n = (bit_cnt != rd_bound);
        end else if (shift_pulse) begin
          rd_shift = 1'b1;
          rd_last  = (bit_cnt == WORD_LAST);
        end
      end
      DRAIN: if (ss_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      addr        <= '0;
      miso_q      <= 1'b0;
      host_rdata  <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      addr_err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
    end else begin
      wr_strobe   <= 1'b0;
      frame_done  <= done_n;
      frame_abort <= abort_n;
      addr_err    <= err_n;
      host_rdata  <= host_ok ? regfile[host_addr] : '0;
      if (state == IDLE && ss_fall) begin
        cpol_q  <= spi.cpol;
        cpha_q  <= spi.cpha;
        bit_cnt <= '0;
      end
      if (hdr_shift || wr_shift) shift_in <= word_bits[DATA_WIDTH-2:0];
      if (hdr_done) begin
        bit_cnt <= '0;
        addr    <= hdr_addr;
        miso_q  <= 1'b0;
        if (!hdr_oob) shift_out <= regfile[hdr_addr];
      end else if (hdr_shift) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (wr_shift) begin
        if (word_done) begin
          bit_cnt       <= '0;
          regfile[addr] <= word_bits;
          wr_strobe     <= 1'b1;
          wr_addr       <= addr;
          wr_data       <= word_bits;
          addr          <= next_addr;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (rd_shift) begin
        miso_q <= shift_out[DATA_WIDTH-1];
        if (rd_last) begin
          bit_cnt   <= '0;
          addr      <= next_addr;
          shift_out <= regfile[next_addr];
        end else begin
          bit_cnt   <= bit_cnt + 1'b1;
          shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_regfile_slave.sv
// tb_spi_burst_regfile_slave: bit-level SPI master driving
// two slaves (DEPTH 32 and 20) against an array model.
module tb_spi_burst_regfile_slave;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int HALF = 60;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic cpol_v = 1'b0, cpha_v = 1'b0, sel = 1'b0;
  int total = 0, bad = 0;

  spi_burst_regfile_slave_if ifa ();
  spi_burst_regfile_slave_if ifb ();

  assign ifa.sck  = sck;
  assign ifa.ss_n = sel ? 1'b1 : ss;
  assign ifa.mosi = mosi;
  assign ifa.cpol = cpol_v;
  assign ifa.cpha = cpha_v;
  assign ifb.sck  = sck;
  assign ifb.ss_n = sel ? ss : 1'b1;
  assign ifb.mosi = mosi;
  assign ifb.cpol = cpol_v;
  assign ifb.cpha = cpha_v;

  logic [AW-1:0] haddr_a = '0, haddr_b = '0;
  logic [DW-1:0] rdata_a, rdata_b, wd_a, wd_b;
  logic [AW-1:0] wa_a, wa_b;
  logic wrs_a, wrs_b, done_a, done_b;
  logic abort_a, abort_b, err_a, err_b;

  spi_burst_regfile_slave #(
    .DATA_WIDTH(DW), .DEPTH(32), .ADDR_WIDTH(AW), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .spi(ifa),
    .host_addr(haddr_a), .host_rdata(rdata_a),
    .wr_strobe(wrs_a), .wr_addr(wa_a), .wr_data(wd_a),
    .frame_done(done_a), .frame_abort(abort_a), .addr_err(err_a)
  );

  spi_burst_regfile_slave #(
    .DATA_WIDTH(DW), .DEPTH(20), .ADDR_WIDTH(AW), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .spi(ifb),
    .host_addr(haddr_b), .host_rdata(rdata_b),
    .wr_strobe(wrs_b), .wr_addr(wa_b), .wr_data(wd_b),
    .frame_done(done_b), .frame_abort(abort_b), .addr_err(err_b)
  );

  logic miso_sel, oe_sel;
  assign miso_sel = sel ? ifb.miso : ifa.miso;
  assign oe_sel   = sel ? ifb.miso_oe : ifa.miso_oe;

  int n_wr = 0, n_done = 0, n_abort = 0, n_err = 0;
  int n_wrb = 0, n_doneb = 0, n_abortb = 0, n_errb = 0, n_oeb = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];

  always @(negedge clk) begin
    if (wrs_a) begin
      n_wr <= n_wr + 1;
      wa_q.push_back(wa_a);
      wd_q.push_back(wd_a);
    end
    if (done_a)  n_done   <= n_done + 1;
    if (abort_a) n_abort  <= n_abort + 1;
    if (err_a)   n_err    <= n_err + 1;
    if (wrs_b)   n_wrb    <= n_wrb + 1;
    if (done_b)  n_doneb  <= n_doneb + 1;
    if (abort_b) n_abortb <= n_abortb + 1;
    if (err_b)   n_errb   <= n_errb + 1;
    if (ifb.miso_oe) n_oeb <= n_oeb + 1;
  end

  logic [DW-1:0] ref_a [32];
  logic tx_q[$];
  logic rx_q[$];
  logic oe_q[$];
  logic [DW-1:0] wr_words[$];
  logic [DW-1:0] got_q[$];
  logic hdr_oe_any, data_oe_all;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    cpol_v = m[1];
    cpha_v = m[0];
  endtask

  task automatic push_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b0;
      if (!cpha_v) begin
        mosi = b;
        #HALF;
        sck = ~cpol_v;
        rx_q.push_back(miso_sel);
        oe_q.push_back(oe_sel);
        #HALF;
        sck = cpol_v;
      end else begin
        sck = ~cpol_v;
        mosi = b;
        #HALF;
        sck = cpol_v;
        rx_q.push_back(miso_sel);
        oe_q.push_back(oe_sel);
        #HALF;
      end
    end
  endtask

  task automatic frame_start();
    tx_q.delete();
    rx_q.delete();
    oe_q.delete();
    sck = cpol_v;
    mosi = 1'b0;
    ss = 1'b1;
    #HALF;
    ss = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    ss = 1'b1;
    #(3 * HALF);
  endtask

  task automatic do_write(input int a);
    frame_start();
    push_word(32'({1'b0, 5'(a)}), 6);
    foreach (wr_words[k]) push_word(wr_words[k], DW);
    spi_bits(6 + DW * wr_words.size());
    frame_end();
    foreach (wr_words[k]) ref_a[(a + k) % 32] = wr_words[k];
  endtask

  task automatic do_read(input int a, input int n);
    logic [DW-1:0] v;
    frame_start();
    push_word(32'({1'b1, 5'(a)}), 6);
    spi_bits(6 + DW * n);
    frame_end();
    got_q.delete();
    hdr_oe_any = 1'b0;
    data_oe_all = 1'b1;
    for (int i = 0; i < 6; i++) hdr_oe_any |= oe_q[i];
    for (int i = 6; i < 6 + DW * n; i++) data_oe_all &= oe_q[i];
    for (int w = 0; w < n; w++) begin
      v = '0;
      for (int b = 0; b < DW; b++) v = {v[DW-2:0], rx_q[6 + DW * w + b]};
      got_q.push_back(v);
    end
  endtask

  task automatic host_chk(input string tag, input int a);
    haddr_a = 5'(a);
    repeat (2) @(negedge clk);
    chk(tag, rdata_a, ref_a[a]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, a0, e0, eb0, wb0, ob0, db0, abb0;
    int a, n;
    foreach (ref_a[i]) ref_a[i] = '0;
    #20;
    chk("rst_miso", 32'(ifa.miso), 32'd0);
    chk("rst_oe", 32'(ifa.miso_oe), 32'd0);
    chk("rst_wrs", 32'(wrs_a), 32'd0);
    chk("rst_flags", 32'({done_a, abort_a, err_a}), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    #20;
    reset_n = 1'b1;
    #(2 * HALF);

    // mode 0 single write
    set_mode(2'd0);
    w0 = n_wr; d0 = n_done; wa_q.delete(); wd_q.delete();
    wr_words = '{32'hDEADBEEF};
    do_write(3);
    chk("w1_strobes", 32'(n_wr - w0), 32'd1);
    chk("w1_addr", 32'(wa_q[0]), 32'd3);
    chk("w1_data", wd_q[0], 32'hDEADBEEF);
    chk("w1_done", 32'(n_done - d0), 32'd1);
    host_chk("w1_host", 3);

    // read reg 3 in all four modes
    wr_words = '{32'hA5A50F0F};
    do_write(3);
    for (int m = 0; m < 4; m++) begin
      set_mode(2'(m));
      d0 = n_done; a0 = n_abort;
      do_read(3, 1);
      chk($sformatf("rd_m%0d_data", m), got_q[0], 32'hA5A50F0F);
      chk($sformatf("rd_m%0d_hdr_oe", m), 32'(hdr_oe_any), 32'd0);
      chk($sformatf("rd_m%0d_dat_oe", m), 32'(data_oe_all), 32'd1);
      chk($sformatf("rd_m%0d_end_oe", m), 32'(ifa.miso_oe), 32'd0);
      chk($sformatf("rd_m%0d_done", m), 32'(n_done - d0), 32'd1);
      chk($sformatf("rd_m%0d_abort", m), 32'(n_abort - a0), 32'd0);
    end

    // burst write wrapping past the last register
    set_mode(2'd1);
    w0 = n_wr; wa_q.delete(); wd_q.delete();
    wr_words = '{32'h1, 32'h2, 32'h3};
    do_write(30);
    chk("burst_strobes", 32'(n_wr - w0), 32'd3);
    chk("burst_wa0", 32'(wa_q[0]), 32'd30);
    chk("burst_wa1", 32'(wa_q[1]), 32'd31);
    chk("burst_wa2", 32'(wa_q[2]), 32'd0);
    host_chk("burst_h30", 30);
    host_chk("burst_h31", 31);
    host_chk("burst_h0", 0);
    set_mode(2'd2);
    do_read(30, 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("burst_rd%0d", k), got_q[k], ref_a[(30 + k) % 32]);

    // abort after 17 data bits
    set_mode(2'd3);
    wr_words = '{$urandom()};
    do_write(5);
    w0 = n_wr; d0 = n_done; a0 = n_abort;
    frame_start();
    push_word(32'({1'b0, 5'd5}), 6);
    push_word(32'h12345678, DW);
    spi_bits(6 + 17);
    frame_end();
    chk("abort_pulse", 32'(n_abort - a0), 32'd1);
    chk("abort_nowr", 32'(n_wr - w0), 32'd0);
    chk("abort_nodone", 32'(n_done - d0), 32'd0);
    host_chk("abort_reg5", 5);

    // out-of-range header on the DEPTH=20 slave
    sel = 1'b1;
    set_mode(2'd0);
    eb0 = n_errb; wb0 = n_wrb; ob0 = n_oeb;
    db0 = n_doneb; abb0 = n_abortb;
    frame_start();
    push_word(32'({1'b0, 5'd25}), 6);
    push_word(32'h55, DW);
    spi_bits(6 + DW);
    frame_end();
    frame_start();
    push_word(32'({1'b1, 5'd25}), 6);
    spi_bits(6 + DW);
    frame_end();
    chk("oob_err", 32'(n_errb - eb0), 32'd2);
    chk("oob_nowr", 32'(n_wrb - wb0), 32'd0);
    chk("oob_oe", 32'(n_oeb - ob0), 32'd0);
    chk("oob_flags", 32'((n_doneb - db0) + (n_abortb - abb0)), 32'd0);
    haddr_b = 5'd25;
    repeat (2) @(negedge clk);
    chk("oob_host", rdata_b, 32'd0);
    sel = 1'b0;

    // reset in the middle of a read
    set_mode(2'd0);
    frame_start();
    push_word(32'({1'b1, 5'd3}), 6);
    spi_bits(6 + 10);
    reset_n = 1'b0;
    #1;
    chk("mrst_miso", 32'(ifa.miso), 32'd0);
    chk("mrst_oe", 32'(ifa.miso_oe), 32'd0);
    #59;
    foreach (ref_a[i]) ref_a[i] = '0;
    reset_n = 1'b1;
    #(2 * HALF);
    w0 = n_wr; d0 = n_done; a0 = n_abort; e0 = n_err;
    push_word(32'({1'b0, 5'd3}), 6);
    push_word(32'hCAFEF00D, DW);
    spi_bits(6 + DW);
    ss = 1'b1;
    #(3 * HALF);
    chk("mrst_ignored",
        32'((n_wr - w0) + (n_done - d0) + (n_abort - a0) + (n_err - e0)),
        32'd0);
    do_read(3, 1);
    chk("mrst_rd_cleared", got_q[0], ref_a[3]);
    wr_words = '{$urandom()};
    do_write(3);
    do_read(3, 1);
    chk("mrst_rd_new", got_q[0], ref_a[3]);

    // randomized bursts
    for (int t = 0; t < 4; t++) begin
      set_mode(2'($urandom_range(0, 3)));
      a = $urandom_range(0, 31);
      n = $urandom_range(1, 3);
      wr_words.delete();
      for (int k = 0; k < n; k++) wr_words.push_back($urandom());
      w0 = n_wr;
      do_write(a);
      chk($sformatf("rnd%0d_strobes", t), 32'(n_wr - w0), 32'(n));
      set_mode(2'($urandom_range(0, 3)));
      d0 = n_done;
      do_read(a, n);
      for (int k = 0; k < n; k++)
        chk($sformatf("rnd%0d_rd%0d", t, k), got_q[k], ref_a[(a + k) % 32]);
      chk($sformatf("rnd%0d_done", t), 32'(n_done - d0), 32'd1);
      host_chk($sformatf("rnd%0d_host", t), $urandom_range(0, 31));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
